// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode constant sets and sizing helpers.
package vga_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        hs_pol;
    logic        vs_pol;
    int unsigned clk_div;
  } vga_timing_t;

  // 640x480@60, 25 MHz pixel rate from a 100 MHz system clock, both syncs active-low.
  localparam vga_timing_t Vga640x480At60 = '{
    h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
    hs_pol:   1'b0, vs_pol: 1'b0, clk_div: 4
  };

  // 800x600@72, 50 MHz pixel rate from a 100 MHz system clock, both syncs active-high.
  localparam vga_timing_t Vga800x600At72 = '{
    h_active: 800, h_fp: 56, h_sync: 120, h_bp: 64,
    v_active: 600, v_fp: 37, v_sync: 6,   v_bp: 23,
    hs_pol:   1'b1, vs_pol: 1'b1, clk_div: 2
  };

  // Full period of one axis: active + front porch + sync + back porch.
  function automatic int unsigned total_len(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed for a counter running 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate clock-enable: one-clk tick every CLK_DIV system clocks.
module vga_pix_tick
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DcW = cnt_width(CLK_DIV);
  localparam logic [DcW-1:0] DcLast = DcW'(CLK_DIV - 1);

  if (CLK_DIV == 0) begin : gen_bad_clk_div
    $error("vga_pix_tick: CLK_DIV must be at least 1");
  end

  logic [DcW-1:0] dc_q, dc_d;

  // Divider wraps at CLK_DIV-1; with CLK_DIV=1 it sits at 0 and tick stays high.
  always_comb begin
    dc_d = (dc_q == DcLast) ? '0 : dc_q + 1'b1;
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dc_q <= '0;
    end else begin
      dc_q <= dc_d;
    end
  end

  assign tick = (dc_q == DcLast);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator on the system clock with a pixel clock-enable.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = Vga640x480At60.h_active,
  parameter int unsigned H_FP     = Vga640x480At60.h_fp,
  parameter int unsigned H_SYNC   = Vga640x480At60.h_sync,
  parameter int unsigned H_BP     = Vga640x480At60.h_bp,
  parameter int unsigned V_ACTIVE = Vga640x480At60.v_active,
  parameter int unsigned V_FP     = Vga640x480At60.v_fp,
  parameter int unsigned V_SYNC   = Vga640x480At60.v_sync,
  parameter int unsigned V_BP     = Vga640x480At60.v_bp,
  parameter bit          HS_POL   = Vga640x480At60.hs_pol,
  parameter bit          VS_POL   = Vga640x480At60.vs_pol,
  parameter int unsigned CLK_DIV  = Vga640x480At60.clk_div,
  parameter int unsigned R_W      = 3,
  parameter int unsigned G_W      = 3,
  parameter int unsigned B_W      = 2,
  localparam int unsigned H_TOTAL = total_len(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = total_len(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned XW      = cnt_width(H_TOTAL),
  localparam int unsigned YW      = cnt_width(V_TOTAL),
  localparam int unsigned DW      = R_W + G_W + B_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data,
  output logic          pix_req,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          tick,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic [R_W-1:0] r,
  output logic [G_W-1:0] g,
  output logic [B_W-1:0] b,
  output logic          frame_start,
  output logic          line_start
);

  if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : gen_bad_timing
    $error("vga_timing_gen: active and sync lengths must be non-zero");
  end

  // Region bounds as inclusive last indices so they always fit the counter width,
  // even when the back porch is zero and the total is a power of two.
  localparam logic [XW-1:0] HActLast   = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] HSyncFirst = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HSyncLast  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [XW-1:0] HLast      = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] VActLast   = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VSyncFirst = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VSyncLast  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [YW-1:0] VLast      = YW'(V_TOTAL - 1);

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [XW-1:0] hc_q, hc_d;
  logic [YW-1:0] vc_q, vc_d;
  logic          h_act, v_act, h_sync, v_sync;

  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [DW-1:0] rgb_q, rgb_d;
  logic          frame_start_q, frame_start_d;
  logic          line_start_q, line_start_d;

  // Raster counters: hc steps each tick, vc steps on the tick where hc wraps.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (tick) begin
      if (hc_q == HLast) begin
        hc_d = '0;
        vc_d = (vc_q == VLast) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // Region decode and the pixel request seen by the upstream source.
  always_comb begin
    h_act   = (hc_q <= HActLast);
    v_act   = (vc_q <= VActLast);
    h_sync  = (hc_q >= HSyncFirst) && (hc_q <= HSyncLast);
    v_sync  = (vc_q >= VSyncFirst) && (vc_q <= VSyncLast);
    pix_req = h_act && v_act;
    x       = pix_req ? hc_q : '0;
    y       = pix_req ? vc_q : '0;
  end

  // Output stage: capture the current position's signals on tick, hold otherwise.
  always_comb begin
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    if (tick) begin
      de_d  = pix_req;
      hs_d  = h_sync ? HS_POL : ~HS_POL;
      vs_d  = v_sync ? VS_POL : ~VS_POL;
      rgb_d = pix_req ? data : '0;
    end
    // Pulses are recomputed every clk so they last exactly one cycle.
    frame_start_d = tick && (hc_q == '0) && (vc_q == '0);
    line_start_d  = tick && (hc_q == '0) && v_act;
  end

  // State registers; reset wins over tick and aborts the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q          <= '0;
      vc_q          <= '0;
      de_q          <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign de          = de_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign r           = rgb_q[DW-1 -: R_W];
  assign g           = rgb_q[B_W +: G_W];
  assign b           = rgb_q[B_W-1:0];
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: small raster, arithmetic reference model, randomized data and resets.
module tb_vga_timing_gen;

  localparam int unsigned HA  = 16;
  localparam int unsigned HFP = 2;
  localparam int unsigned HSY = 3;
  localparam int unsigned HBP = 2;
  localparam int unsigned VA  = 6;
  localparam int unsigned VFP = 1;
  localparam int unsigned VSY = 2;
  localparam int unsigned VBP = 1;
  localparam int unsigned D   = 3;
  localparam bit          HSP = 1'b0;
  localparam bit          VSP = 1'b1;
  localparam int unsigned HT  = HA + HFP + HSY + HBP;  // 23
  localparam int unsigned VT  = VA + VFP + VSY + VBP;  // 10

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       pix_req, tick, de, hs, vs, fs, ls;
  logic [4:0] x;
  logic [3:0] y;
  logic [2:0] r, g;
  logic [1:0] b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .HS_POL (HSP), .VS_POL (VSP), .CLK_DIV (D),
    .R_W (3), .G_W (3), .B_W (2)
  ) dut (
    .clk (clk), .rst (rst), .data (data), .pix_req (pix_req), .x (x), .y (y),
    .tick (tick), .de (de), .hs (hs), .vs (vs), .r (r), .g (g), .b (b),
    .frame_start (fs), .line_start (ls)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus controls, written by the main sequence.
  bit init_rst = 1'b1;
  bit force_rst = 1'b0;
  bit rst_rand_en = 1'b0;
  bit meas_en = 1'b0;
  int mode = 0;  // 0 random data, 1 constant E0, 2 data = current x

  // Reference model state: clk edges since reset release and the expected registered outputs.
  bit         valid = 1'b0;
  int         n = 0;
  int         p, ph, pv, cur_h, cur_v;
  bit         act;
  logic       e_de, e_hs, e_vs, e_fs, e_ls;
  logic [7:0] e_rgb;

  // Frame statistics for hand-computed literal checks.
  bit   started = 1'b0;
  int   c_clk, c_ls, c_de, c_hs, c_vs;
  int   l_clk = 0, l_ls = 0, l_de = 0, l_hs = 0, l_vs = 0;
  int   frames_seen = 0, tot = 0, last_hs_edge = -1, hs_period = 0, first_fs_n = -1;
  logic hs_prev = ~HSP;

  // Model, compare and drive, once per negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        valid = 1'b1;
        n     = 0;
        e_de  = 1'b0; e_hs = ~HSP; e_vs = ~VSP; e_rgb = 8'h00; e_fs = 1'b0; e_ls = 1'b0;
      end else if (valid) begin
        n++;
        if (n % D == 0) begin
          // The k-th tick after release presents pixel number k-1 of the raster.
          p     = n / D - 1;
          ph    = p % HT;
          pv    = (p / HT) % VT;
          act   = (ph < HA) && (pv < VA);
          e_de  = act;
          e_hs  = (ph >= HA + HFP && ph < HA + HFP + HSY) ? HSP : ~HSP;
          e_vs  = (pv >= VA + VFP && pv < VA + VFP + VSY) ? VSP : ~VSP;
          e_rgb = act ? data : 8'h00;
          e_fs  = (ph == 0) && (pv == 0);
          e_ls  = (ph == 0) && (pv < VA);
        end else begin
          e_fs = 1'b0;
          e_ls = 1'b0;
        end
      end
      cur_h = (n / D) % HT;
      cur_v = (n / D / HT) % VT;

      if (valid) begin
        act = (cur_h < HA) && (cur_v < VA);
        chk("tick", 32'(tick), 32'(((n + 1) % D) == 0));
        chk("pix_req", 32'(pix_req), 32'(act));
        chk("x", 32'(x), act ? 32'(cur_h) : 32'd0);
        chk("y", 32'(y), act ? 32'(cur_v) : 32'd0);
        chk("de", 32'(de), 32'(e_de));
        chk("hs", 32'(hs), 32'(e_hs));
        chk("vs", 32'(vs), 32'(e_vs));
        chk("rgb", 32'({r, g, b}), 32'(e_rgb));
        chk("frame_start", 32'(fs), 32'(e_fs));
        chk("line_start", 32'(ls), 32'(e_ls));
      end

      if (meas_en) begin
        tot++;
        if (fs === 1'b1) begin
          if (first_fs_n < 0) first_fs_n = n;
          if (started) begin
            l_clk = c_clk; l_ls = c_ls; l_de = c_de; l_hs = c_hs; l_vs = c_vs;
            frames_seen++;
          end
          started = 1'b1;
          c_clk = 0; c_ls = 0; c_de = 0; c_hs = 0; c_vs = 0;
        end
        c_clk++;
        if (ls === 1'b1) c_ls++;
        if (de === 1'b1) c_de++;
        if (hs === HSP) c_hs++;
        if (vs === VSP) c_vs++;
        if (hs === HSP && hs_prev !== HSP) begin
          if (last_hs_edge >= 0) hs_period = tot - last_hs_edge;
          last_hs_edge = tot;
        end
        hs_prev = hs;
      end

      rst = init_rst || force_rst || (rst_rand_en && ($urandom_range(0, 299) == 0));
      case (mode)
        1:       data = 8'hE0;
        2:       data = 8'(cur_h);
        default: data = 8'($urandom);
      endcase
    end
  end

  // Main sequence.
  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    init_rst = 1'b0;
    meas_en  = 1'b1;
    mode     = 1;
    @(negedge clk); #1;
    chk("post_reset_de", 32'(de), 32'd0);
    chk("post_reset_hs", 32'(hs), 32'd1);
    chk("post_reset_vs", 32'(vs), 32'd0);

    // Two full frames of constant colour, then pin frame-level counts.
    repeat (2 * 690 + 100) @(posedge clk);
    meas_en = 1'b0;
    chk("first_fs_delay", 32'(first_fs_n), 32'd3);
    chk("frames_seen", 32'(frames_seen), 32'd2);
    chk("frame_clks", 32'(l_clk), 32'd690);
    chk("line_starts", 32'(l_ls), 32'd6);
    chk("de_clks", 32'(l_de), 32'd288);
    chk("hs_active_clks", 32'(l_hs), 32'd90);
    chk("vs_active_clks", 32'(l_vs), 32'd138);
    chk("hs_period", 32'(hs_period), 32'd69);

    // Data follows x: colour must show the previous tick's x.
    mode = 2;
    repeat (700) @(posedge clk);

    // One-clk reset in the middle of an active line.
    cnt = 0;
    do begin
      @(negedge clk); #1;
      cnt++;
    end while (!(cur_h == 10 && cur_v == 3 && !rst) && cnt < 2000);
    chk("mid_line_reached", 32'(cnt < 2000), 32'd1);
    force_rst = 1'b1;
    @(negedge clk); #1;
    force_rst = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_de", 32'(de), 32'd0);
    chk("mid_rst_hs", 32'(hs), 32'd1);
    chk("mid_rst_vs", 32'(vs), 32'd0);
    chk("mid_rst_rgb", 32'({r, g, b}), 32'd0);
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    cnt = 0;
    do begin
      @(negedge clk); #1;
      cnt++;
    end while (fs !== 1'b1 && cnt < 20);
    chk("mid_rst_fs_delay", 32'(cnt), 32'd3);

    // Random data with sporadic resets.
    mode        = 0;
    rst_rand_en = 1'b1;
    repeat (3000) @(posedge clk);
    rst_rand_en = 1'b0;
    repeat (50) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
